sprite_layer_renderer: RTL and testbench
========================================

Name: sprite_layer_renderer

Overview:
Parametrised sprite pixel pipeline for the VGA path. Draws one movable palette-indexed sprite at a run-time position, with power-of-two scaling and horizontal/vertical mirroring. Index TRANSPARENT_IDX shows an incoming background colour, so instances can be chained as layers. Sits between the VGA controller (DrawX/DrawY/blank) and the colour outputs, and drives an external synchronous sprite ROM.

Parameters:
SPR_W, 32, sprite width in texels (power of two)
SPR_H, 32, sprite height in texels
IDX_W, 3, palette index width (2^IDX_W palette entries)
COORD_W, 10, width of DrawX/DrawY/position
TRANSPARENT_IDX, 0, palette index treated as transparent

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset  in  1  synchronous, active-high
DrawX  in  COORD_W  current pixel column
DrawY  in  COORD_W  current pixel row
blank  in  1  high = visible region
bg_rgb  in  12  background colour {r,g,b}, aligned with DrawX
frame_start  in  1  one-cycle pulse; latches shadow controls
pos_x, pos_y  in  COORD_W each  sprite top-left (shadow)
scale_log2  in  2  scale 1x/2x/4x/8x (shadow)
flip_h, flip_v, sprite_en  in  1 each  mirror and enable controls (shadow)
pal_we  in  1  palette write strobe
pal_waddr  in  IDX_W  palette entry to write
pal_wdata  in  12  palette colour {r,g,b}
rom_addr  out  clog2(SPR_W*SPR_H)  sprite ROM address, registered
rom_q  in  IDX_W  ROM data, valid 1 cycle after rom_addr
red, green, blue  out  4 each  output colour
pixel_hit  out  1  opaque sprite texel drawn this pixel

Behaviour:
- Reset (synchronous, active-high): active controls, pipeline regs, rom_addr, red/green/blue, pixel_hit = 0; all palette entries = 12'h000.
- Shadow latch: on frame_start, active regs <= pos_x, pos_y, scale_log2, flip_h, flip_v, sprite_en. Otherwise they hold, so a mid-frame change does not tear the image. frame_start together with reset: reset wins.
- Box test: uses COORD_W+4-bit unsigned math, no wrap. ext_w = SPR_W << scale, ext_h = SPR_H << scale. in_box = en && DrawX >= px && DrawX < px+ext_w && DrawY >= py && DrawY < py+ext_h. A box extending past 640/480 is clipped naturally.
- Texel: col = (DrawX-px) >> scale; row = (DrawY-py) >> scale. If flip_h, col = SPR_W-1-col; if flip_v, row = SPR_H-1-row. addr = row*SPR_W + col, done as shift/concat with no multiplier.
- Pipeline, fixed latency 3 (inputs at cycle t -> outputs at cycle t+3):
  - S1 (t+1): rom_addr, in_box, blank and bg_rgb registered.
  - S2 (t+2): rom_q valid; in_box, blank and bg delayed one more stage.
  - S3 (t+3), output regs:
    - if !blank_d: rgb = 0, hit = 0.
    - else if in_box_d && rom_q != TRANSPARENT_IDX: rgb = palette[rom_q], hit = 1.
    - else: rgb = bg_d, hit = 0.
- Outside the box, rom_addr holds its last value (no spurious toggling required; value unspecified to verification).
- Palette: registered array written on posedge when pal_we. A same-cycle write and S3 read of the same entry outputs the old colour; the new colour applies from the next cycle.
- Reset mid-frame: outputs are 0 for the reset cycle and up to 3 following cycles (pipeline refills). The sprite stays disabled until the next frame_start.

Decomposition:
- Package sprite_pkg: rgb12_t struct {r,g,b 4-bit}, scale_t enum (SCALE_1X..SCALE_8X), localparam helper for address width (clog2(SPR_W*SPR_H)).
- Sub-module sprite_palette_ram (2^IDX_W x 12, sync write, async read, sync reset clear).
- Box/address logic and pipeline stay in the top.

Test Plan:
- Reset, then sprite_en=1, pos=(100,50), scale 1x, frame_start; drive DrawX=100, DrawY=50, blank=1 -> rom_addr=0 at t+1; with rom_q=3 and palette[3]=12'hF80, rgb=F,8,0 and hit=1 at t+3.
- Scale 4x, pos=(0,0), DrawX=13, DrawY=9 -> rom_addr = 2*32+3 = 67. DrawX=128 (ext_w=128) -> in_box=0, output = bg_rgb.
- flip_h=1, flip_v=1, scale 1x, pos=(0,0), DrawX=0, DrawY=0 -> rom_addr=1023 (SPR_W=SPR_H=32).
- rom_q=TRANSPARENT_IDX inside box with bg_rgb=12'h00F -> rgb=0,0,F, hit=0. With blank=0 instead -> rgb=0, hit=0.
- Change pos_x mid-frame without frame_start -> addresses unchanged. After a frame_start pulse -> new position used from the next cycle.
- pal_we writing entry 3 in the same cycle S3 reads entry 3 -> old colour out; new colour on the next pixel. Assert reset mid-stream -> all outputs 0 the following cycle.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite layer renderer: 12-bit colour,
// scale encoding and the sprite ROM address width.
package sprite_pkg;

  localparam int RGB_W = 12;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic [1:0] {
    SCALE_1X = 2'd0,
    SCALE_2X = 2'd1,
    SCALE_4X = 2'd2,
    SCALE_8X = 2'd3
  } scale_t;

  function automatic int addr_width(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/sprite_palette_ram.sv
// Small colour palette: synchronous write, asynchronous read, cleared to black
// on reset. A read of an entry being written returns the old colour.
module sprite_palette_ram
  import sprite_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  rgb12_t           wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output rgb12_t           rdata_o
);

  localparam int DEPTH = 1 << IDX_W;

  rgb12_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sprite_layer_renderer.sv
// One palette-indexed sprite layer: box test, texel addressing with scale and
// mirroring, and a fixed 3-cycle pipeline onto the colour outputs.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W           = 32,
  parameter int SPR_H           = 32,
  parameter int IDX_W           = 3,
  parameter int COORD_W         = 10,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic                                  vga_clk,
  input  logic                                  reset,
  input  logic [COORD_W-1:0]                    DrawX,
  input  logic [COORD_W-1:0]                    DrawY,
  input  logic                                  blank,
  input  logic [11:0]                           bg_rgb,
  input  logic                                  frame_start,
  input  logic [COORD_W-1:0]                    pos_x,
  input  logic [COORD_W-1:0]                    pos_y,
  input  logic [1:0]                            scale_log2,
  input  logic                                  flip_h,
  input  logic                                  flip_v,
  input  logic                                  sprite_en,
  input  logic                                  pal_we,
  input  logic [IDX_W-1:0]                      pal_waddr,
  input  logic [11:0]                           pal_wdata,
  output logic [addr_width(SPR_W, SPR_H)-1:0]   rom_addr,
  input  logic [IDX_W-1:0]                      rom_q,
  output logic [3:0]                            red,
  output logic [3:0]                            green,
  output logic [3:0]                            blue,
  output logic                                  pixel_hit
);

  localparam int AW = addr_width(SPR_W, SPR_H);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = AW - CW;
  localparam int BW = COORD_W + 4;

  // Shadow controls, only updated at frame boundaries to avoid tearing.
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  scale_t             scale_q;
  logic               flip_h_q, flip_v_q, en_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      scale_q  <= SCALE_1X;
      flip_h_q <= 1'b0;
      flip_v_q <= 1'b0;
      en_q     <= 1'b0;
    end else if (frame_start) begin
      pos_x_q  <= pos_x;
      pos_y_q  <= pos_y;
      scale_q  <= scale_t'(scale_log2);
      flip_h_q <= flip_h;
      flip_v_q <= flip_v;
      en_q     <= sprite_en;
    end
  end

  logic [1:0]    shamt;
  logic [BW-1:0] dx, dy, px, py, ext_w, ext_h, off_x, off_y;
  logic          in_box_d;
  logic [CW-1:0] col, col_f;
  logic [RW-1:0] row, row_f;
  logic [AW-1:0] addr_d;

  assign shamt = scale_q;
  assign dx    = BW'(DrawX);
  assign dy    = BW'(DrawY);
  assign px    = BW'(pos_x_q);
  assign py    = BW'(pos_y_q);
  assign ext_w = BW'(SPR_W) << shamt;
  assign ext_h = BW'(SPR_H) << shamt;

  assign in_box_d = en_q && (dx >= px) && (dx < px + ext_w)
                         && (dy >= py) && (dy < py + ext_h);

  // Offsets wrap when outside the box, but the address is then not used.
  assign off_x = dx - px;
  assign off_y = dy - py;
  assign col   = CW'(off_x >> shamt);
  assign row   = RW'(off_y >> shamt);
  // SPR_W is a power of two, so SPR_W-1-col is a bitwise inversion.
  assign col_f  = flip_h_q ? ~col : col;
  assign row_f  = flip_v_q ? (RW'(SPR_H - 1) - row) : row;
  assign addr_d = {row_f, col_f};

  // S1
  logic [AW-1:0] rom_addr_q;
  logic          s1_in_box_q, s1_blank_q;
  rgb12_t        s1_bg_q;
  // S2
  logic          s2_in_box_q, s2_blank_q;
  rgb12_t        s2_bg_q;
  // S3
  rgb12_t        out_rgb_q, out_rgb_d;
  logic          hit_q, hit_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr_q  <= '0;
      s1_in_box_q <= 1'b0;
      s1_blank_q  <= 1'b0;
      s1_bg_q     <= '0;
      s2_in_box_q <= 1'b0;
      s2_blank_q  <= 1'b0;
      s2_bg_q     <= '0;
      out_rgb_q   <= '0;
      hit_q       <= 1'b0;
    end else begin
      if (in_box_d) begin
        rom_addr_q <= addr_d;
      end
      s1_in_box_q <= in_box_d;
      s1_blank_q  <= blank;
      s1_bg_q     <= rgb12_t'(bg_rgb);
      s2_in_box_q <= s1_in_box_q;
      s2_blank_q  <= s1_blank_q;
      s2_bg_q     <= s1_bg_q;
      out_rgb_q   <= out_rgb_d;
      hit_q       <= hit_d;
    end
  end

  rgb12_t pal_rdata;

  sprite_palette_ram #(
    .IDX_W (IDX_W)
  ) u_palette (
    .clk_i   (vga_clk),
    .rst_i   (reset),
    .we_i    (pal_we),
    .waddr_i (pal_waddr),
    .wdata_i (rgb12_t'(pal_wdata)),
    .raddr_i (rom_q),
    .rdata_o (pal_rdata)
  );

  always_comb begin
    out_rgb_d = s2_bg_q;
    hit_d     = 1'b0;
    if (!s2_blank_q) begin
      out_rgb_d = '0;
    end else if (s2_in_box_q && (rom_q != IDX_W'(TRANSPARENT_IDX))) begin
      out_rgb_d = pal_rdata;
      hit_d     = 1'b1;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign red       = out_rgb_q.r;
  assign green     = out_rgb_q.g;
  assign blue      = out_rgb_q.b;
  assign pixel_hit = hit_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed bench for sprite_layer_renderer with a small synchronous ROM model.
module tb_sprite_layer_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [11:0] bg_rgb;
  logic        frame_start;
  logic [9:0]  pos_x, pos_y;
  logic [1:0]  scale_log2;
  logic        flip_h, flip_v, sprite_en;
  logic        pal_we;
  logic [2:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_q;
  logic [3:0]  red, green, blue;
  logic        pixel_hit;

  logic [2:0]  rom_mem [1024];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  sprite_layer_renderer dut (
    .vga_clk     (clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .bg_rgb      (bg_rgb),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .scale_log2  (scale_log2),
    .flip_h      (flip_h),
    .flip_v      (flip_v),
    .sprite_en   (sprite_en),
    .pal_we      (pal_we),
    .pal_waddr   (pal_waddr),
    .pal_wdata   (pal_wdata),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pixel_hit   (pixel_hit)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'd5;
    rom_mem[0]    = 3'd3;
    rom_mem[33]   = 3'd3;
    rom_mem[1023] = 3'd0;

    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; bg_rgb = '0;
    frame_start = 1'b0; pos_x = '0; pos_y = '0; scale_log2 = '0;
    flip_h = 1'b0; flip_v = 1'b0; sprite_en = 1'b0;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    repeat (2) step();
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_hit", pixel_hit, 1'b0);
    chk("rst_addr", rom_addr, 10'd0);
    reset = 1'b0;

    pal_we = 1'b1; pal_waddr = 3'd3; pal_wdata = 12'hF80; step();
    pal_waddr = 3'd5; pal_wdata = 12'h0A5; step();
    pal_we = 1'b0;

    // Basic 1x placement at (100,50)
    pos_x = 10'd100; pos_y = 10'd50; scale_log2 = 2'd0; sprite_en = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1; bg_rgb = 12'h123;
    step();
    chk("addr_origin", rom_addr, 10'd0);
    step(); step();
    chk("rgb_origin", {red, green, blue}, 12'hF80);
    chk("hit_origin", pixel_hit, 1'b1);

    // 4x scale at (0,0)
    pos_x = '0; pos_y = '0; scale_log2 = 2'd2;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd13; DrawY = 10'd9; step();
    chk("addr_4x", rom_addr, 10'd67);
    step(); step();
    chk("rgb_4x", {red, green, blue}, 12'h0A5);
    chk("hit_4x", pixel_hit, 1'b1);
    DrawX = 10'd127; step();
    chk("addr_4x_edge", rom_addr, 10'd95);
    DrawX = 10'd128; bg_rgb = 12'h456; step(); step(); step();
    chk("rgb_4x_out", {red, green, blue}, 12'h456);
    chk("hit_4x_out", pixel_hit, 1'b0);

    // Both mirrors, 1x
    scale_log2 = 2'd0; flip_h = 1'b1; flip_v = 1'b1;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd1; DrawY = 10'd0; step();
    chk("addr_flip_1", rom_addr, 10'd1022);
    DrawX = 10'd0; bg_rgb = 12'h00F; step();
    chk("addr_flip_0", rom_addr, 10'd1023);
    step(); step();
    chk("rgb_transp", {red, green, blue}, 12'h00F);
    chk("hit_transp", pixel_hit, 1'b0);
    blank = 1'b0; step(); step(); step();
    chk("rgb_blank", {red, green, blue}, 12'h000);
    chk("hit_blank", pixel_hit, 1'b0);

    // Shadow controls ignore mid-frame changes
    blank = 1'b1; flip_h = 1'b0; flip_v = 1'b0; pos_x = 10'd100; pos_y = 10'd50;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    pos_x = 10'd200; DrawX = 10'd101; DrawY = 10'd50; step();
    chk("addr_shadow_hold", rom_addr, 10'd1);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    DrawX = 10'd201; DrawY = 10'd51; step();
    chk("addr_shadow_new", rom_addr, 10'd33);
    step(); step();
    chk("rgb_shadow_new", {red, green, blue}, 12'hF80);
    chk("hit_shadow_new", pixel_hit, 1'b1);

    // Palette write colliding with the S3 read of the same entry
    pal_we = 1'b1; pal_waddr = 3'd3; pal_wdata = 12'h7E1; step();
    pal_we = 1'b0;
    chk("rgb_pal_old", {red, green, blue}, 12'hF80);
    step();
    chk("rgb_pal_new", {red, green, blue}, 12'h7E1);

    // Reset mid-stream, asserted together with frame_start
    reset = 1'b1; frame_start = 1'b1; step();
    chk("rgb_midrst", {red, green, blue}, 12'h000);
    chk("hit_midrst", pixel_hit, 1'b0);
    chk("addr_midrst", rom_addr, 10'd0);
    reset = 1'b0; frame_start = 1'b0; bg_rgb = 12'h321;
    step(); step(); step();
    chk("rgb_post_rst", {red, green, blue}, 12'h321);
    chk("hit_post_rst", pixel_hit, 1'b0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    step(); step(); step();
    chk("rgb_pal_cleared", {red, green, blue}, 12'h000);
    chk("hit_pal_cleared", pixel_hit, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
